// File: rtl/truth_table_sweeper.sv
// Steps a combinational gate through every input vector, samples its output after a
// programmable settle time and reports the Cello-style truth-table code and expected-code match.
`timescale 1ns/1ps

module truth_table_sweeper #(
  parameter  int N_IN   = 3,
  parameter  int SETTLE = 4,
  localparam int W      = 2**N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [W-1:0]    expected,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    code,
  output logic            match
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam logic [7:0]      WAIT_LOAD = 8'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_t          r_state;
  state_t          w_next_state;
  logic [N_IN-1:0] r_vec;
  logic [7:0]      r_wait;
  logic [W-1:0]    r_shift;
  logic [W-1:0]    r_exp;
  logic [W-1:0]    r_code;
  logic            r_match;
  logic [W-1:0]    w_shift_next;
  logic            w_sample;
  logic            w_last_vec;

  // Vector 0 is shifted in first, so it ends up in the MSB of the code.
  assign w_shift_next = {r_shift[W-2:0], gate_out};
  assign w_sample     = (r_state == ST_SETTLE) && (r_wait == '0) && !abort;
  assign w_last_vec   = (r_vec == VEC_LAST);

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    gate_in      = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_SETTLE;
      end
      ST_SETTLE: begin
        gate_in = r_vec;
        busy    = 1'b1;
        if (abort)                      w_next_state = ST_IDLE;
        else if (w_sample && w_last_vec) w_next_state = ST_FINISH;
      end
      ST_FINISH: begin
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec   <= '0;
      r_wait  <= '0;
      r_shift <= '0;
      r_exp   <= '0;
      r_code  <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_exp   <= expected;
            r_vec   <= '0;
            r_wait  <= WAIT_LOAD;
            r_shift <= '0;
          end
        end
        ST_SETTLE: begin
          if (w_sample) begin
            r_shift <= w_shift_next;
            if (w_last_vec) begin
              r_code  <= w_shift_next;
              r_match <= (w_shift_next == r_exp);
            end else begin
              r_vec  <= r_vec + 1'b1;
              r_wait <= WAIT_LOAD;
            end
          end else if (!abort) begin
            r_wait <= r_wait - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign code  = r_code;
  assign match = r_match;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: table-driven sweeps, abort/reset corner cases
// and random truth tables checked against a per-vector reference model.
`timescale 1ns/1ps

module tb_truth_table_sweeper;

  localparam int N_IN = 3;
  localparam int W    = 8;

  typedef enum int {G_NAND, G_AND, G_NOR, G_TABLE} gate_e;

  typedef struct {
    int          sel;
    gate_e       kind;
    logic [W-1:0] exp_in;
    logic [W-1:0] code_exp;
    logic        match_exp;
    bit          spam;
    bit          with_abort;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, start0, start1, abort;
  logic [W-1:0]    expected;
  logic [N_IN-1:0] gate_in0, gate_in1;
  logic            gate_out0, gate_out1;
  logic            busy0, busy1, done0, done1, match0, match1;
  logic [W-1:0]    code0, code1;

  gate_e        g_kind;
  logic [W-1:0] g_tt;
  int           sel;
  int           n_checks = 0;
  int           n_errors = 0;

  // Gate under evaluation; v[2] is in1. G_TABLE looks up bit v of g_tt.
  function automatic logic gate_fn(gate_e k, logic [W-1:0] tt, logic [N_IN-1:0] v);
    case (k)
      G_NAND:  return !(v[2] & v[1] & v[0]);
      G_AND:   return  (v[2] & v[1] & v[0]);
      G_NOR:   return !(v[2] | v[1] | v[0]);
      default: return tt[v];
    endcase
  endfunction

  function automatic logic [W-1:0] ref_code(gate_e k, logic [W-1:0] tt);
    logic [W-1:0] c = '0;
    for (int i = 0; i < W; i++) c[W-1-i] = gate_fn(k, tt, N_IN'(i));
    return c;
  endfunction

  assign gate_out0 = gate_fn(g_kind, g_tt, gate_in0);
  assign gate_out1 = gate_fn(g_kind, g_tt, gate_in1);

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .expected(expected),
    .gate_in(gate_in0), .gate_out(gate_out0), .busy(busy0), .done(done0),
    .code(code0), .match(match0)
  );

  truth_table_sweeper #(.N_IN(N_IN), .SETTLE(1)) u_dut_fast (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .expected(expected),
    .gate_in(gate_in1), .gate_out(gate_out1), .busy(busy1), .done(done1),
    .code(code1), .match(match1)
  );

  logic [N_IN-1:0] s_gate_in;
  logic            s_busy, s_done, s_match;
  logic [W-1:0]    s_code;
  always_comb begin
    s_gate_in = (sel == 0) ? gate_in0 : gate_in1;
    s_busy    = (sel == 0) ? busy0    : busy1;
    s_done    = (sel == 0) ? done0    : done1;
    s_code    = (sel == 0) ? code0    : code1;
    s_match   = (sel == 0) ? match0   : match1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // Starts a sweep on the selected instance and checks every cycle of it plus three after.
  task automatic run_sweep(input logic [W-1:0] exp, input bit spam, input bit with_abort,
                           input string tag);
    int s;
    int last;
    logic [W-1:0] rc;
    s    = (sel == 0) ? 4 : 1;
    last = W * s + 1;
    rc   = ref_code(g_kind, g_tt);
    expected = exp;
    abort    = with_abort;
    set_start(1'b1);
    step();
    set_start(1'b0);
    abort = 1'b0;
    for (int c = 1; c <= last; c++) begin
      check($sformatf("%s gate_in c%0d", tag, c), 32'(s_gate_in), (c < last) ? 32'((c - 1) / s) : 32'd0);
      check($sformatf("%s busy c%0d", tag, c), 32'(s_busy), 32'(c < last));
      check($sformatf("%s done c%0d", tag, c), 32'(s_done), 32'(c == last));
      if (c == last) begin
        check($sformatf("%s code", tag), 32'(s_code), 32'(rc));
        check($sformatf("%s match", tag), 32'(s_match), 32'(rc == exp));
      end
      set_start(spam && ((c % 5 == 0) || (c == last)));
      step();
    end
    set_start(1'b0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s idle busy +%0d", tag, c), 32'(s_busy), 32'd0);
      check($sformatf("%s idle done +%0d", tag, c), 32'(s_done), 32'd0);
      step();
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      if (done0) n++;
      step();
    end
  endtask

  vec_t tbl[6];

  initial begin
    int n_done;
    logic [W-1:0] rc, ex;

    tbl[0] = '{0, G_NAND, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{0, G_AND,  8'hFE, 8'h01, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{0, G_AND,  8'h01, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1, G_NOR,  8'h80, 8'h80, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{0, G_NAND, 8'hFE, 8'hFE, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{0, G_AND,  8'h01, 8'h01, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; abort = 1'b0; expected = '0;
    g_kind = G_NAND; g_tt = '0; sel = 0;
    step(); step();
    for (int i = 0; i < 2; i++) begin
      sel = i;
      check($sformatf("reset gate_in%0d", i), 32'(s_gate_in), 32'd0);
      check($sformatf("reset busy%0d", i),    32'(s_busy),    32'd0);
      check($sformatf("reset done%0d", i),    32'(s_done),    32'd0);
      check($sformatf("reset code%0d", i),    32'(s_code),    32'd0);
      check($sformatf("reset match%0d", i),   32'(s_match),   32'd0);
    end
    rst_n = 1'b1;
    step();

    foreach (tbl[i]) begin
      sel    = tbl[i].sel;
      g_kind = tbl[i].kind;
      run_sweep(tbl[i].exp_in, tbl[i].spam, tbl[i].with_abort, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d held code", i),  32'(s_code),  32'(tbl[i].code_exp));
      check($sformatf("tbl%0d held match", i), 32'(s_match), 32'(tbl[i].match_exp));
    end

    // Abort while vector 3 is driven; code/match keep the AND3 result from tbl[5].
    sel = 0; g_kind = G_NAND; expected = 8'hFE;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (int c = 1; c < 13; c++) step();
    check("abort pre gate_in", 32'(gate_in0), 32'd3);
    abort = 1'b1; step(); abort = 1'b0;
    check("abort busy",    32'(busy0),    32'd0);
    check("abort gate_in", 32'(gate_in0), 32'd0);
    check("abort done",    32'(done0),    32'd0);
    check("abort code",    32'(code0),    32'h01);
    check("abort match",   32'(match0),   32'd1);
    count_dones(40, n_done);
    check("abort no done", 32'(n_done), 32'd0);
    run_sweep(8'hFE, 1'b0, 1'b0, "post_abort");

    // Reset while vector 5 is driven.
    expected = 8'hFE;
    start0 = 1'b1; step(); start0 = 1'b0;
    for (int c = 1; c < 21; c++) step();
    check("rst pre gate_in", 32'(gate_in0), 32'd5);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("rst gate_in", 32'(gate_in0), 32'd0);
    check("rst busy",    32'(busy0),    32'd0);
    check("rst done",    32'(done0),    32'd0);
    check("rst code",    32'(code0),    32'd0);
    check("rst match",   32'(match0),   32'd0);
    count_dones(40, n_done);
    check("rst no done", 32'(n_done), 32'd0);

    // Random truth tables on either instance.
    g_kind = G_TABLE;
    for (int i = 0; i < 8; i++) begin
      sel  = int'($urandom_range(0, 1));
      g_tt = W'($urandom);
      rc   = ref_code(G_TABLE, g_tt);
      ex   = ($urandom_range(0, 1) == 1) ? rc : W'($urandom);
      run_sweep(ex, bit'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
